// File: rtl/phv_assembler_pkg.sv
// Shared widths, PHV layout offsets, value type codes and FSM encoding for
// the PHV assembler.
package phv_assembler_pkg;
  localparam int NUM_PER_TYPE = 8;
  localparam int META_LEN     = 256;
  localparam int VAL_LEN      = 48;
  localparam int SEQ_W        = 3;
  localparam int PHV_LEN      = (2 + 4 + 6) * 8 * NUM_PER_TYPE + META_LEN;

  localparam int OFF_2B = META_LEN;
  localparam int OFF_4B = OFF_2B + 16 * NUM_PER_TYPE;
  localparam int OFF_6B = OFF_4B + 32 * NUM_PER_TYPE;

  typedef enum logic [1:0] {
    VT_NONE = 2'b00,
    VT_2B   = 2'b01,
    VT_4B   = 2'b10,
    VT_6B   = 2'b11
  } val_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASM      = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_e;
endpackage

// File: rtl/phv_assembler_out_reg.sv
// One-entry valid/ready holding register. 'free' means a load this cycle
// will not overwrite an entry that has not been handed off yet.
module phv_out_reg #(
  parameter int W = 1024
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         free
);
  assign free = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/phv_assembler.sv
// Collects typed sub-parser values into a PHV accumulator, appends packet
// metadata and hands the finished PHV to a one-entry output register.
module phv_assembler
  import phv_assembler_pkg::*;
(
  input  logic                clk,
  input  logic                areset,
  input  logic                hdr_valid,
  output logic                hdr_ready,
  input  logic [META_LEN-1:0] meta_in,
  input  logic                val_valid,
  input  logic [VAL_LEN-1:0]  val_in,
  input  logic [1:0]          val_type,
  input  logic [SEQ_W-1:0]    val_seq,
  input  logic                parse_done,
  output logic                phv_valid,
  input  logic                phv_ready,
  output logic [PHV_LEN-1:0]  phv_out,
  output logic [15:0]         drop_cnt
);
  state_e               state;
  logic [PHV_LEN-1:0]   acc;
  logic [PHV_LEN-1:0]   acc_wr;
  logic                 out_free;
  logic                 load;
  logic                 drop_ev;

  // acc_wr is the accumulator with this cycle's value merged in; it feeds both
  // the accumulator and the output load so a value arriving with parse_done
  // still lands in the emitted PHV.
  always_comb begin
    acc_wr = acc;
    if (state == ST_ASM && val_valid) begin
      case (val_type_e'(val_type))
        VT_2B:   acc_wr[OFF_2B + 16 * int'(val_seq) +: 16] = val_in[15:0];
        VT_4B:   acc_wr[OFF_4B + 32 * int'(val_seq) +: 32] = val_in[31:0];
        VT_6B:   acc_wr[OFF_6B + 48 * int'(val_seq) +: 48] = val_in[47:0];
        default: acc_wr = acc;
      endcase
    end
  end

  assign load    = ((state == ST_ASM && parse_done) || state == ST_WAIT_OUT) && out_free;
  assign drop_ev = (val_valid | parse_done) && (state != ST_ASM);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      hdr_ready <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (drop_ev && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          hdr_ready <= 1'b1;
          if (hdr_valid && hdr_ready) begin
            acc       <= PHV_LEN'(meta_in);
            state     <= ST_ASM;
            hdr_ready <= 1'b0;
          end
        end
        ST_ASM: begin
          acc <= acc_wr;
          if (parse_done) begin
            if (out_free) begin
              state     <= ST_IDLE;
              hdr_ready <= 1'b1;
            end else begin
              state <= ST_WAIT_OUT;
            end
          end
        end
        ST_WAIT_OUT: begin
          if (out_free) begin
            state     <= ST_IDLE;
            hdr_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  phv_out_reg #(.W(PHV_LEN)) u_out (
    .clk       (clk),
    .areset    (areset),
    .load      (load),
    .load_data (acc_wr),
    .out_ready (phv_ready),
    .out_valid (phv_valid),
    .out_data  (phv_out),
    .free      (out_free)
  );
endmodule

// File: tb/tb_phv_assembler.sv
// Directed bench for phv_assembler: a table of single-value packets plus
// hand-written sequences for back-pressure, bypass, saturation and reset.
`timescale 1ns/1ps
module tb_phv_assembler;
  logic          clk = 1'b0;
  logic          areset;
  logic          hdr_valid;
  logic          hdr_ready;
  logic [255:0]  meta_in;
  logic          val_valid;
  logic [47:0]   val_in;
  logic [1:0]    val_type;
  logic [2:0]    val_seq;
  logic          parse_done;
  logic          phv_valid;
  logic          phv_ready;
  logic [1023:0] phv_out;
  logic [15:0]   drop_cnt;

  int vecs = 0;
  int errs = 0;

  phv_assembler dut (
    .clk(clk), .areset(areset), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .meta_in(meta_in), .val_valid(val_valid), .val_in(val_in), .val_type(val_type),
    .val_seq(val_seq), .parse_done(parse_done), .phv_valid(phv_valid),
    .phv_ready(phv_ready), .phv_out(phv_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  typ;
    logic [2:0]  seq;
    logic [47:0] val;
    int          off;
    int          w;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [1023:0] put(logic [1023:0] p, int off, int w, logic [47:0] v);
    for (int b = 0; b < w; b++) p[off + b] = v[b];
    return p;
  endfunction

  function automatic logic [47:0] get(logic [1023:0] p, int off, int w);
    logic [47:0] r = '0;
    for (int b = 0; b < w; b++) r[b] = p[off + b];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_phv(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int first;
    vecs++;
    if (act !== exp) begin
      errs++;
      first = -1;
      for (int b = 0; b < 1024; b++) if (first < 0 && act[b] !== exp[b]) first = b;
      $display("FAIL %s: phv differs from bit %0d, got word %h want word %h", nm, first,
               act[first/32*32 +: 32], exp[first/32*32 +: 32]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [255:0] m);
    hdr_valid = 1'b1; meta_in = m;
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic send_val(input logic [1:0] t, input logic [2:0] s, input logic [47:0] v);
    val_valid = 1'b1; val_type = t; val_seq = s; val_in = v;
    tick();
    val_valid = 1'b0;
  endtask

  task automatic send_done();
    parse_done = 1'b1;
    tick();
    parse_done = 1'b0;
  endtask

  initial begin
    logic [255:0]  m1, m2;
    logic [1023:0] e1, e2;
    bit            seen;

    tbl[0] = '{2'b01, 3'd0, 48'h0000_0000_1234, 256, 16, 48'h1234};
    tbl[1] = '{2'b01, 3'd7, 48'h0000_0000_BEEF, 368, 16, 48'hBEEF};
    tbl[2] = '{2'b10, 3'd0, 48'h0000_CAFE_F00D, 384, 32, 48'hCAFE_F00D};
    tbl[3] = '{2'b10, 3'd7, 48'h0000_DEAD_BEEF, 608, 32, 48'hDEAD_BEEF};
    tbl[4] = '{2'b11, 3'd0, 48'h0123_4567_89AB, 640, 48, 48'h0123_4567_89AB};
    tbl[5] = '{2'b11, 3'd7, 48'hFEDC_BA98_7654, 976, 48, 48'hFEDC_BA98_7654};
    tbl[6] = '{2'b01, 3'd4, 48'hFFFF_FFFF_ABCD, 320, 16, 48'hABCD};
    tbl[7] = '{2'b10, 3'd5, 48'h1234_5678_9ABC, 544, 32, 48'h5678_9ABC};
    tbl[8] = '{2'b00, 3'd3, 48'hFFFF_FFFF_FFFF, 0,   0,  48'h0};

    areset = 1'b1; hdr_valid = 0; meta_in = '0; val_valid = 0; val_in = '0;
    val_type = 2'b00; val_seq = '0; parse_done = 0; phv_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_ready", hdr_ready, 0);
    chk("rst_phv_valid", phv_valid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk_phv("rst_phv_out", phv_out, '0);
    areset = 1'b0;
    tick();
    chk("post_rst_hdr_ready", hdr_ready, 1);

    // scenario 1: three values of different widths
    m1 = {32{8'hA5}};
    send_hdr(m1);
    send_val(2'b01, 3'd2, 48'h1234);
    send_val(2'b10, 3'd7, 48'hDEAD_BEEF);
    send_val(2'b11, 3'd0, 48'h0123_4567_89AB);
    chk("s1_valid_before_done", phv_valid, 0);
    send_done();
    chk("s1_valid", phv_valid, 1);
    chk("s1_2b_s2", get(phv_out, 288, 16), 64'h1234);
    chk("s1_4b_s7", get(phv_out, 608, 32), 64'hDEAD_BEEF);
    chk("s1_6b_s0", get(phv_out, 640, 48), 64'h0123_4567_89AB);
    e1 = put(put(put(1024'(m1), 288, 16, 48'h1234), 608, 32, 48'hDEAD_BEEF), 640, 48, 48'h0123_4567_89AB);
    chk_phv("s1_phv", phv_out, e1);
    tick();
    chk("s1_valid_drop", phv_valid, 0);

    // table: one value per packet, boundaries of every slot range
    for (int i = 0; i < 9; i++) begin
      m1 = {8{32'hC0DE_0000 + 32'(i)}};
      send_hdr(m1);
      send_val(tbl[i].typ, tbl[i].seq, tbl[i].val);
      send_done();
      chk($sformatf("tbl%0d_valid", i), phv_valid, 1);
      chk($sformatf("tbl%0d_field", i), get(phv_out, tbl[i].off, tbl[i].w), 64'(tbl[i].exp));
      chk_phv($sformatf("tbl%0d_phv", i), phv_out, put(1024'(m1), tbl[i].off, tbl[i].w, tbl[i].exp));
      tick();
    end

    // scenario 2: back-pressure, second packet waits then follows back-to-back
    phv_ready = 1'b0;
    m1 = {8{32'h1111_0001}};
    m2 = {8{32'h2222_0002}};
    e1 = put(1024'(m1), 256, 16, 48'h1111);
    e2 = put(1024'(m2), 736, 48, 48'h2222_2222_2222);
    send_hdr(m1);
    send_val(2'b01, 3'd0, 48'h1111);
    send_done();
    send_hdr(m2);
    send_val(2'b11, 3'd2, 48'h2222_2222_2222);
    send_done();
    chk("s2_hdr_ready_wait", hdr_ready, 0);
    chk("s2_valid_hold", phv_valid, 1);
    chk_phv("s2_pkt1_hold", phv_out, e1);
    tick();
    chk_phv("s2_pkt1_stable", phv_out, e1);
    phv_ready = 1'b1;
    tick();
    chk("s2_b2b_valid", phv_valid, 1);
    chk_phv("s2_pkt2", phv_out, e2);
    chk("s2_hdr_ready_back", hdr_ready, 1);
    tick();
    chk("s2_valid_drop", phv_valid, 0);

    // scenario 3: value in the same cycle as parse_done
    m1 = {8{32'h3333_BEEF}};
    send_hdr(m1);
    val_valid = 1'b1; val_type = 2'b01; val_seq = 3'd3; val_in = 48'hBEEF;
    parse_done = 1'b1;
    tick();
    val_valid = 1'b0; parse_done = 1'b0;
    chk("s3_valid", phv_valid, 1);
    chk("s3_bypass", get(phv_out, 304, 16), 64'hBEEF);
    tick();

    // scenario 4: last write wins, 2B masks upper bits
    m1 = {8{32'h4444_0004}};
    send_hdr(m1);
    send_val(2'b10, 3'd1, 48'h1111_1111);
    send_val(2'b10, 3'd1, 48'h2222_2222);
    send_val(2'b01, 3'd0, 48'hFFFF_FFFF_5A5A);
    send_done();
    chk("s4_last_wins", get(phv_out, 416, 32), 64'h2222_2222);
    chk_phv("s4_phv", phv_out, put(put(1024'(m1), 416, 32, 48'h2222_2222), 256, 16, 48'h5A5A));
    tick();

    // scenario 5: drops in IDLE, saturation, no PHV emitted
    chk("s5_drop_base", drop_cnt, 0);
    send_val(2'b01, 3'd0, 48'h1);
    send_val(2'b10, 3'd1, 48'h2);
    send_val(2'b11, 3'd2, 48'h3);
    chk("s5_drop3", drop_cnt, 3);
    val_valid = 1'b1; val_type = 2'b01; parse_done = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("s5_drop_both", drop_cnt, 4);
    seen = 1'b0;
    for (int i = 0; i < 65530; i++) begin
      tick();
      if (phv_valid) seen = 1'b1;
    end
    chk("s5_drop_fffe", drop_cnt, 16'hFFFE);
    for (int i = 0; i < 4466; i++) begin
      tick();
      if (phv_valid) seen = 1'b1;
    end
    parse_done = 1'b0;
    chk("s5_drop_sat", drop_cnt, 16'hFFFF);
    chk("s5_no_phv", seen, 0);
    chk("s5_hdr_ready", hdr_ready, 1);

    // scenario 6: reset mid-packet with a held PHV
    phv_ready = 1'b0;
    send_hdr({8{32'h5555_0005}});
    send_done();
    send_hdr({8{32'h6666_0006}});
    send_val(2'b01, 3'd1, 48'hAAAA);
    send_val(2'b11, 3'd5, 48'hBBBB_BBBB_BBBB);
    #2 areset = 1'b1;
    #1;
    chk("s6_rst_valid", phv_valid, 0);
    chk("s6_rst_hdr_ready", hdr_ready, 0);
    chk("s6_rst_drop", drop_cnt, 0);
    chk_phv("s6_rst_phv", phv_out, '0);
    @(negedge clk);
    areset = 1'b0;
    tick();
    chk("s6_hdr_ready", hdr_ready, 1);
    phv_ready = 1'b1;
    m1 = {8{32'h7777_0007}};
    send_hdr(m1);
    send_done();
    chk("s6_valid", phv_valid, 1);
    chk_phv("s6_clean_phv", phv_out, 1024'(m1));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
